// File: rtl/klein_pkg.sv
// Shared KLEIN definitions: S-box, MixColumn, key-length to round-count mapping
// and the controller state type.
package klein_pkg;

    typedef enum logic {IDLE, RUN} klein_fsm_t;

    function automatic int klein_rounds(input int key_bits);
        case (key_bits)
            64:      return 12;
            80:      return 16;
            96:      return 20;
            default: return 0;
        endcase
    endfunction

    // 4-bit KLEIN S-box (an involution, so it also serves as its own inverse)
    function automatic logic [3:0] klein_sbox(input logic [3:0] x);
        case (x)
            4'h0: return 4'h7;
            4'h1: return 4'h4;
            4'h2: return 4'hA;
            4'h3: return 4'h9;
            4'h4: return 4'h1;
            4'h5: return 4'hF;
            4'h6: return 4'hB;
            4'h7: return 4'h0;
            4'h8: return 4'hC;
            4'h9: return 4'h3;
            4'hA: return 4'h2;
            4'hB: return 4'h6;
            4'hC: return 4'h8;
            4'hD: return 4'hE;
            4'hE: return 4'hD;
            default: return 4'h5;
        endcase
    endfunction

    function automatic logic [7:0] klein_sbox_byte(input logic [7:0] b);
        return {klein_sbox(b[7:4]), klein_sbox(b[3:0])};
    endfunction

    function automatic logic [7:0] klein_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Forward 32-bit MixColumn, byte 0 in bits [31:24]
    function automatic logic [31:0] klein_mixcolumn(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        a0 = c[31:24];
        a1 = c[23:16];
        a2 = c[15:8];
        a3 = c[7:0];
        return {klein_xtime(a0) ^ klein_xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ klein_xtime(a1) ^ klein_xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ klein_xtime(a2) ^ klein_xtime(a3) ^ a3,
                klein_xtime(a0) ^ a0 ^ a1 ^ a2 ^ klein_xtime(a3)};
    endfunction

endpackage

// File: rtl/klein_round.sv
// One combinational KLEIN round on the 64-bit state plus the matching key step.
module klein_round
    import klein_pkg::*;
#(
    parameter int KEY_BITS = 64
) (
    input  logic [63:0]         s,
    input  logic [KEY_BITS-1:0] k,
    input  logic [4:0]          i,
    output logic [63:0]         s_next,
    output logic [KEY_BITS-1:0] k_next
);

    localparam int HALF = KEY_BITS / 2;

    logic [63:0]     s_key;
    logic [63:0]     s_sub;
    logic [63:0]     s_rot;
    logic [HALF-1:0] a_rot;
    logic [HALF-1:0] b_rot;
    logic [HALF-1:0] k_hi;
    logic [HALF-1:0] k_lo;

    assign s_key = s ^ k[KEY_BITS-1 -: 64];

    for (genvar n = 0; n < 16; n++) begin : g_sub
        assign s_sub[4*n +: 4] = klein_sbox(s_key[4*n +: 4]);
    end

    assign s_rot  = {s_sub[47:0], s_sub[63:48]};
    assign s_next = {klein_mixcolumn(s_rot[63:32]), klein_mixcolumn(s_rot[31:0])};

    // Each key half rotates left by one byte before the Feistel swap
    assign a_rot = {k[KEY_BITS-9:HALF], k[KEY_BITS-1:KEY_BITS-8]};
    assign b_rot = {k[HALF-9:0], k[HALF-1:HALF-8]};

    always_comb begin
        k_hi = b_rot;
        k_lo = a_rot ^ b_rot;
        k_hi[HALF-17 -: 8] = b_rot[HALF-17 -: 8] ^ {3'b000, i};
        k_lo[HALF-9 -: 8]  = klein_sbox_byte(k_lo[HALF-9 -: 8]);
        k_lo[HALF-17 -: 8] = klein_sbox_byte(k_lo[HALF-17 -: 8]);
        k_next = {k_hi, k_lo};
    end

endmodule

// File: rtl/klein_cipher_param.sv
// Iterative KLEIN-64/80/96 encryptor, UNROLL rounds per clock, start/busy/valid handshake.
module klein_cipher_param
    import klein_pkg::*;
#(
    parameter int KEY_BITS = 64,
    parameter int UNROLL   = 1
) (
    input  logic                iclk,
    input  logic                ireset_n,
    input  logic                istart,
    input  logic [63:0]         iblock,
    input  logic [KEY_BITS-1:0] ikey,
    output logic                obusy,
    output logic                ovalid,
    output logic [63:0]         oblock
);

    localparam int         ROUNDS    = klein_rounds(KEY_BITS);
    localparam logic [4:0] LAST_RCNT = 5'(ROUNDS - UNROLL + 1);

    if (KEY_BITS != 64 && KEY_BITS != 80 && KEY_BITS != 96) begin : g_bad_key
        $error("klein_cipher_param: KEY_BITS must be 64, 80 or 96");
    end
    if ((UNROLL != 1 && UNROLL != 2 && UNROLL != 4) || (ROUNDS % UNROLL) != 0) begin : g_bad_unroll
        $error("klein_cipher_param: UNROLL must be 1, 2 or 4 and divide the round count");
    end

    klein_fsm_t          fsm_q;
    klein_fsm_t          fsm_d;
    logic [63:0]         state_q;
    logic [KEY_BITS-1:0] kstate_q;
    logic [4:0]          rcnt_q;
    logic                load;
    logic                finish;
    logic [63:0]         s_last;
    logic [KEY_BITS-1:0] k_last;

    // Round chain: stage u handles round index rcnt+u
    for (genvar u = 0; u < UNROLL; u++) begin : g_round
        logic [63:0]         s_in;
        logic [63:0]         s_out;
        logic [KEY_BITS-1:0] k_in;
        logic [KEY_BITS-1:0] k_out;

        if (u == 0) begin : g_first
            assign s_in = state_q;
            assign k_in = kstate_q;
        end else begin : g_next
            assign s_in = g_round[u-1].s_out;
            assign k_in = g_round[u-1].k_out;
        end

        klein_round #(.KEY_BITS(KEY_BITS)) u_round (
            .s      (s_in),
            .k      (k_in),
            .i      (rcnt_q + 5'(u)),
            .s_next (s_out),
            .k_next (k_out)
        );
    end

    assign s_last = g_round[UNROLL-1].s_out;
    assign k_last = g_round[UNROLL-1].k_out;

    always_ff @(posedge iclk) begin
        if (!ireset_n) fsm_q <= IDLE;
        else           fsm_q <= fsm_d;
    end

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (istart) fsm_d = RUN;
            RUN:     if (finish) fsm_d = IDLE;
            default: fsm_d = IDLE;
        endcase
    end

    always_comb begin
        obusy  = (fsm_q == RUN);
        load   = (fsm_q == IDLE) && istart;
        finish = (fsm_q == RUN) && (rcnt_q == LAST_RCNT);
    end

    // Working registers are wiped on completion so the key does not linger
    always_ff @(posedge iclk) begin
        if (!ireset_n) begin
            state_q  <= '0;
            kstate_q <= '0;
            rcnt_q   <= '0;
            ovalid   <= 1'b0;
            oblock   <= '0;
        end else begin
            ovalid <= 1'b0;
            if (load) begin
                state_q  <= iblock;
                kstate_q <= ikey;
                rcnt_q   <= 5'd1;
            end else if (finish) begin
                oblock   <= s_last ^ k_last[KEY_BITS-1 -: 64];
                ovalid   <= 1'b1;
                state_q  <= '0;
                kstate_q <= '0;
                rcnt_q   <= '0;
            end else if (obusy) begin
                state_q  <= s_last;
                kstate_q <= k_last;
                rcnt_q   <= rcnt_q + 5'(UNROLL);
            end
        end
    end

endmodule
